// File: rtl/glb_psum_collector.sv
// glb_psum_collector
// Collects per-column partial sums from the global PE set in strict column
// order 0..K-1, buffers them in a first-word-fall-through FIFO and emits them
// as one valid/ready stream tagged with source column and row-end flag.
// Optional feature: define GLB_PSUM_STATS_EN to add the beat_cnt / row_cnt
// output-handshake statistics counters.
module glb_psum_collector #(
   parameter int DATA_WIDTH = 16,
   parameter int NUM_COL    = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                                clk,
   input  logic                                rstn,
   input  logic                                flush,
   input  logic [7:0]                          kernel_size,
   input  logic [NUM_COL-1:0]                  col_valid,
   input  logic [NUM_COL-1:0][DATA_WIDTH-1:0]  col_data,
   output logic [NUM_COL-1:0]                  col_ready,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_WIDTH-1:0]               out_data,
   output logic [$clog2(NUM_COL)-1:0]          out_col,
   output logic                                out_last,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_count,
   output logic                                flush_busy
`ifdef GLB_PSUM_STATS_EN
   ,
   output logic [31:0]                         beat_cnt,
   output logic [15:0]                         row_cnt
`endif
);

   localparam int COL_W = $clog2(NUM_COL);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_GATHER,
      S_FLUSH
   } state_e;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] data;
      logic [COL_W-1:0]      col;
      logic                  last;
   } entry_t;

   state_e           state_q, state_d;
   logic             load_k;
   logic [COL_W-1:0] ptr_q;
   logic [COL_W-1:0] klast_q;   // K-1, the index of the row's last column
   logic [COL_W-1:0] klast_new;
   logic [AW-1:0]    wr_q, rd_q;
   logic [CW-1:0]    cnt_q;
   entry_t           mem_q [FIFO_DEPTH];
   entry_t           head;

   logic gather, full, empty, push, pop, ptr_last;

   // Clamp the requested kernel width into 1..NUM_COL and express it as K-1
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      klast_new = '0;
      if (kernel_size == 8'd0) begin
         klast_new = '0;
      end else if (int'(kernel_size) > NUM_COL) begin
         klast_new = COL_W'(NUM_COL - 1);
      end else begin
         klast_new = COL_W'(kernel_size - 8'd1);
      end
   end

   // Next-state logic; flush overrides everything and re-enters FLUSH each cycle it is high
   always_comb begin
      state_d = state_q;
      load_k  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            state_d = S_GATHER;
            load_k  = 1'b1;
         end
         S_GATHER: state_d = S_GATHER;
         S_FLUSH: begin
            state_d = S_GATHER;
            load_k  = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
      if (flush) begin
         state_d = S_FLUSH;
         load_k  = 1'b0;
      end
   end

   assign gather    = (state_q == S_GATHER);
   assign full      = (cnt_q == CW'(FIFO_DEPTH));
   assign empty     = (cnt_q == '0);
   assign ptr_last  = (ptr_q == klast_q);
   assign push      = gather && !full && col_valid[ptr_q];
   assign out_valid = !empty && (state_q != S_FLUSH);
   assign pop       = out_valid && out_ready;
   assign head      = mem_q[rd_q];

   assign col_ready  = (gather && !full) ? ({{(NUM_COL-1){1'b0}}, 1'b1} << ptr_q) : '0;
   assign out_data   = out_valid ? head.data : '0;
   assign out_col    = out_valid ? head.col  : '0;
   assign out_last   = out_valid ? head.last : 1'b0;
   assign fifo_count = cnt_q;
   assign flush_busy = flush || (state_q == S_FLUSH);

   // State, column pointer, latched K and FIFO pointers/occupancy
   always_ff @(posedge clk or negedge rstn) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rstn) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         klast_q <= '0;
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (flush || !gather) begin
            ptr_q <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
         end else begin
            if (push) begin
               wr_q  <= wr_q + 1'b1;
               ptr_q <= ptr_last ? '0 : ptr_q + 1'b1;
            end
            if (pop) begin
               rd_q <= rd_q + 1'b1;
            end
            if (push && !pop) begin
               cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
               cnt_q <= cnt_q - 1'b1;
            end
         end
         if (load_k) begin
            klast_q <= klast_new;
         end
      end
   end

   // FIFO storage write port
   always_ff @(posedge clk) begin
      // NOTE: storage is not reset; outputs are masked by out_valid, so stale words are never visible.
      if (push) begin
         mem_q[wr_q] <= '{data: col_data[ptr_q], col: ptr_q, last: ptr_last};
      end
   end

`ifdef GLB_PSUM_STATS_EN
   logic [31:0] beat_q;
   logic [15:0] row_q;

   // Output handshake and row-end counters, cleared by reset and by flush
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         beat_q <= '0;
         row_q  <= '0;
      end else if (flush || (state_q == S_FLUSH)) begin
         beat_q <= '0;
         row_q  <= '0;
      end else if (pop) begin
         beat_q <= beat_q + 1'b1;
         if (head.last) begin
            row_q <= row_q + 1'b1;
         end
      end
   end

   assign beat_cnt = beat_q;
   assign row_cnt  = row_q;
`endif

endmodule

// File: tb/tb_glb_psum_collector.sv
// Self-checking bench for glb_psum_collector: directed scenarios followed by a
// randomized phase, all compared every cycle against a queue-based reference
// model of the collector's ordering, FIFO and flush behaviour.
module tb_glb_psum_collector;

   localparam int DW = 16;
   localparam int NC = 8;
   localparam int FD = 16;

   localparam int PH_IDLE   = 0;
   localparam int PH_GATHER = 1;
   localparam int PH_FLUSH  = 2;

   logic                    clk = 1'b0;
   logic                    rstn = 1'b0;
   logic                    flush = 1'b0;
   logic [7:0]              kernel_size = 8'd1;
   logic [NC-1:0]           col_valid = '0;
   logic [NC-1:0][DW-1:0]   col_data = '0;
   logic                    out_ready = 1'b0;
   logic [NC-1:0]           col_ready;
   logic                    out_valid;
   logic [DW-1:0]           out_data;
   logic [2:0]              out_col;
   logic                    out_last;
   logic [4:0]              fifo_count;
   logic                    flush_busy;
`ifdef GLB_PSUM_STATS_EN
   logic [31:0]             beat_cnt;
   logic [15:0]             row_cnt;
`endif

   always #5 clk = ~clk;

   glb_psum_collector #(
      .DATA_WIDTH(DW),
      .NUM_COL(NC),
      .FIFO_DEPTH(FD)
   ) dut (
      .clk(clk),
      .rstn(rstn),
      .flush(flush),
      .kernel_size(kernel_size),
      .col_valid(col_valid),
      .col_data(col_data),
      .col_ready(col_ready),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .out_col(out_col),
      .out_last(out_last),
      .fifo_count(fifo_count),
      .flush_busy(flush_busy)
`ifdef GLB_PSUM_STATS_EN
      ,
      .beat_cnt(beat_cnt),
      .row_cnt(row_cnt)
`endif
   );

   // Reference model: a queue of entries plus the gather pointer, K and mode
   typedef struct {
      logic [DW-1:0] d;
      int            col;
      bit            last;
   } ent_t;

   ent_t mq[$];
   int   m_phase;
   int   m_ptr;
   int   m_k;
   int   m_beat;
   int   m_row;

   int tests = 0;
   int fails = 0;
   int acc   = 0;   // accepts observed on the DUT's column handshake

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int clamp_k(input int ks);
      if (ks == 0) return 1;
      if (ks > NC) return NC;
      return ks;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_phase = PH_IDLE;
      m_ptr   = 0;
      m_k     = 1;
      m_beat  = 0;
      m_row   = 0;
   endtask

   task automatic check_outputs();
      logic [NC-1:0] er;
      bit            ev;
      er = '0;
      if (m_phase == PH_GATHER && mq.size() < FD) er[m_ptr] = 1'b1;
      ev = (m_phase != PH_FLUSH) && (mq.size() > 0);
      check("col_ready", col_ready, er);
      check("out_valid", out_valid, ev);
      check("out_data", out_data, ev ? mq[0].d : '0);
      check("out_col", out_col, ev ? mq[0].col : 0);
      check("out_last", out_last, ev ? mq[0].last : 1'b0);
      check("fifo_count", fifo_count, mq.size());
      check("flush_busy", flush_busy, flush || (m_phase == PH_FLUSH));
`ifdef GLB_PSUM_STATS_EN
      check("beat_cnt", beat_cnt, m_beat);
      check("row_cnt", row_cnt, m_row);
`endif
   endtask

   // Advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      bit full, ev, push, pop;
      if (!rstn) return;
      full = (mq.size() == FD);
      ev   = (m_phase != PH_FLUSH) && (mq.size() > 0);
      push = (m_phase == PH_GATHER) && !full && col_valid[m_ptr];
      pop  = ev && out_ready;
      if (flush) begin
         mq.delete();
         m_ptr   = 0;
         m_phase = PH_FLUSH;
         m_beat  = 0;
         m_row   = 0;
      end else begin
         if (pop) begin
            m_beat++;
            if (mq[0].last) m_row++;
            void'(mq.pop_front());
         end
         if (push) begin
            mq.push_back('{col_data[m_ptr], m_ptr, (m_ptr == m_k - 1)});
            m_ptr = (m_ptr == m_k - 1) ? 0 : m_ptr + 1;
         end
         if (m_phase != PH_GATHER) begin
            m_k     = clamp_k(int'(kernel_size));
            m_ptr   = 0;
            m_phase = PH_GATHER;
         end
      end
   endtask

   // One clock: settle, compare, record DUT accepts, advance model, cross the edge
   task automatic tick();
      #1;
      check_outputs();
      if (|(col_valid & col_ready)) acc++;
      model_edge();
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset from wherever we are; returns at posedge+1 with rstn released
   task automatic do_reset();
      rstn  = 1'b0;
      flush = 1'b0;
      model_reset();
      #1;
      check_outputs();
      check("rst_count", fifo_count, 5'd0);
      check("rst_valid", out_valid, 1'b0);
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   task automatic do_flush();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
   endtask

   initial begin
      model_reset();

      // Reset, then one IDLE cycle, then column 0 is offered
      kernel_size = 8'd3;
      do_reset();
      tick();
      check("idle_ready", col_ready, 8'h01);
      check("idle_count", fifo_count, 5'd0);

      // Ordered gather at K=3
      for (int i = 0; i < NC; i++) col_data[i] = 16'h10 + 16'(i);
      col_valid = '1;
      out_ready = 1'b1;
      tick();
      check("gather_head0", {out_data, out_col, out_last}, {16'h10, 3'd0, 1'b0});
      tick();
      check("gather_head1", {out_data, out_col, out_last}, {16'h11, 3'd1, 1'b0});
      tick();
      check("gather_head2", {out_data, out_col, out_last}, {16'h12, 3'd2, 1'b1});
      repeat (9) tick();

      // Out-of-order valid at K=4
      col_valid   = '0;
      kernel_size = 8'd4;
      do_flush();
      out_ready = 1'b0;
      col_valid = 8'b0000_0100;
      repeat (5) tick();
      check("ooo_none", fifo_count, 5'd0);
      col_valid = 8'b0000_0101;
      tick();
      check("ooo_col0", fifo_count, 5'd1);
      tick();
      check("ooo_wait1", fifo_count, 5'd1);
      col_valid = 8'b0000_0111;
      tick();
      tick();
      check("ooo_col2", fifo_count, 5'd3);
      check("ooo_head", out_col, 3'd0);

      // Backpressure with kernel_size=12 clamped to 8
      kernel_size = 8'd12;
      do_flush();
      col_valid = '1;
      out_ready = 1'b0;
      acc = 0;
      repeat (20) tick();
      check("bp_accepted", acc, 16);
      check("bp_full", fifo_count, 5'd16);
      check("bp_ready", col_ready, 8'h00);
      out_ready = 1'b1;
      repeat (10) tick();
      check("bp_one_per_pop", acc, 25);
      check("bp_level", fifo_count, 5'd15);
      col_valid = '0;
      repeat (16) tick();
      check("bp_drained", fifo_count, 5'd0);

      // kernel_size=0 behaves as K=1
      kernel_size = 8'd0;
      do_flush();
      col_valid = '1;
      repeat (6) tick();
      check("k0_col", out_col, 3'd0);
      check("k0_last", out_last, 1'b1);

      // Flush with five entries queued
      kernel_size = 8'd8;
      do_flush();
      out_ready = 1'b0;
      repeat (5) tick();
      check("fl_queued", fifo_count, 5'd5);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      #1;
      check("fl_count0", fifo_count, 5'd0);
      check("fl_busy2", flush_busy, 1'b1);
      check("fl_ready_low", col_ready, 8'h00);
      tick();
      check("fl_busy_done", flush_busy, 1'b0);
      check("fl_ptr0", col_ready, 8'h01);

`ifdef GLB_PSUM_STATS_EN
      // Statistics: nine pops at K=3 give three row ends
      kernel_size = 8'd3;
      col_valid = '0;
      do_flush();
      col_valid = '1;
      out_ready = 1'b1;
      repeat (10) tick();
      check("st_beat9", beat_cnt, 32'd9);
      check("st_row3", row_cnt, 16'd3);
      col_valid = '0;
      out_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("st_beat_clr", beat_cnt, 32'd0);
      check("st_row_clr", row_cnt, 16'd0);
      tick();
`endif

      // Asynchronous reset in the middle of traffic
      kernel_size = 8'd5;
      do_flush();
      col_valid = '1;
      out_ready = 1'b0;
      repeat (4) tick();
      #2;
      do_reset();
      tick();

      // Randomized traffic
      for (int n = 0; n < 600; n++) begin
         col_valid = NC'($urandom);
         for (int i = 0; i < NC; i++) col_data[i] = DW'($urandom);
         out_ready   = ($urandom_range(0, 3) != 0);
         flush       = ($urandom_range(0, 40) == 0);
         kernel_size = 8'($urandom_range(0, 12));
         tick();
      end
      flush = 1'b0;
      col_valid = '0;
      out_ready = 1'b1;
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
